// File: rtl/message_capture_pkg.sv
// Shared definitions for the message capture block: FSM state encoding and
// the ASCII control characters it reacts to.
package message_capture_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] SPACE = 8'h20;

  function automatic logic is_terminator(input logic [7:0] ch);
    return (ch == CR) || (ch == LF);
  endfunction

endpackage

// File: rtl/message_capture.sv
// Assembles UART characters into a fixed-width, space-padded message and holds
// it for the printer until acknowledged; bytes arriving while held are dropped.
module message_capture
  import message_capture_pkg::*;
#(
  parameter int MSG_LEN = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   new_rx_data,
  input  logic                   msg_ack,
  output logic [8*MSG_LEN-1:0]   bits_out,
  output logic [3:0]             msg_len,
  output logic                   msg_valid,
  output logic                   overrun
);

  localparam logic [8*MSG_LEN-1:0] BLANK     = {MSG_LEN{SPACE}};
  localparam logic [3:0]           LAST_SLOT = 4'(MSG_LEN - 1);

  state_t                state_q;
  logic [8*MSG_LEN-1:0]  bits_q;
  logic [3:0]            len_q;
  logic                  valid_q;
  logic                  overrun_q;

  // Filling the last slot terminates the message on the same edge, so the
  // length can never step past MSG_LEN while collecting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      bits_q    <= BLANK;
      len_q     <= 4'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (new_rx_data) begin
            if (is_terminator(rx_data)) begin
              if (len_q != 4'd0) begin
                state_q <= HOLD;
                valid_q <= 1'b1;
              end
            end else if (rx_data == BS) begin
              if (len_q != 4'd0) begin
                bits_q[8*(int'(len_q) - 1) +: 8] <= SPACE;
                len_q                            <= len_q - 4'd1;
              end
            end else begin
              bits_q[8*int'(len_q) +: 8] <= rx_data;
              len_q                      <= len_q + 4'd1;
              if (len_q == LAST_SLOT) begin
                state_q <= HOLD;
                valid_q <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          // A byte arriving alongside the ack is still lost; ack takes priority.
          if (new_rx_data) begin
            overrun_q <= 1'b1;
          end
          if (msg_ack) begin
            state_q <= COLLECT;
            bits_q  <= BLANK;
            len_q   <= 4'd0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign bits_out  = bits_q;
  assign msg_len   = len_q;
  assign msg_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_message_capture.sv
// Directed self-checking bench for message_capture: each task drives one
// scenario and compares outputs against hand-computed values.
module tb_message_capture;

  localparam int MSG_LEN = 9;
  localparam logic [71:0] ALL_SP = {9{8'h20}};

  logic                 clk;
  logic                 rst_n;
  logic [7:0]           rx_data;
  logic                 new_rx_data;
  logic                 msg_ack;
  logic [8*MSG_LEN-1:0] bits_out;
  logic [3:0]           msg_len;
  logic                 msg_valid;
  logic                 overrun;

  int checks = 0;
  int fails  = 0;

  message_capture #(.MSG_LEN(MSG_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .msg_ack     (msg_ack),
    .bits_out    (bits_out),
    .msg_len     (msg_len),
    .msg_valid   (msg_valid),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data     = b;
    new_rx_data = 1'b1;
    cycle();
    new_rx_data = 1'b0;
    rx_data     = 8'h00;
  endtask

  task automatic ack();
    msg_ack = 1'b1;
    cycle();
    msg_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    checks++; if (bits_out !== ALL_SP) begin fails++; $display("[TB] FAIL reset_bits: got %h expected %h", bits_out, ALL_SP); end
    checks++; if (msg_len !== 4'd0) begin fails++; $display("[TB] FAIL reset_len: got %0d expected 0", msg_len); end
    checks++; if (msg_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", msg_valid); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_hi_cr();
    send(8'h48);
    send(8'h49);
    checks++; if (msg_len !== 4'd2) begin fails++; $display("[TB] FAIL hi_len: got %0d expected 2", msg_len); end
    checks++; if (msg_valid !== 1'b0) begin fails++; $display("[TB] FAIL hi_valid_early: got %b expected 0", msg_valid); end
    send(8'h0D);
    checks++; if (msg_valid !== 1'b1) begin fails++; $display("[TB] FAIL hi_valid: got %b expected 1", msg_valid); end
    checks++; if (msg_len !== 4'd2) begin fails++; $display("[TB] FAIL hi_len_held: got %0d expected 2", msg_len); end
    checks++; if (bits_out !== {{7{8'h20}}, 8'h49, 8'h48}) begin fails++; $display("[TB] FAIL hi_bits: got %h expected %h", bits_out, {{7{8'h20}}, 8'h49, 8'h48}); end
    ack();
    checks++; if (msg_valid !== 1'b0 || msg_len !== 4'd0 || bits_out !== ALL_SP) begin fails++; $display("[TB] FAIL hi_ack_clear: got valid=%b len=%0d bits=%h expected valid=0 len=0 bits=%h", msg_valid, msg_len, bits_out, ALL_SP); end
  endtask

  task automatic test_full();
    logic [71:0] exp_full;
    logic [7:0]  ch;
    exp_full = {8'h49, 8'h48, 8'h47, 8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41};
    ch = 8'h41;
    for (int i = 0; i < 8; i++) begin
      send(ch);
      ch = ch + 8'd1;
    end
    checks++; if (msg_valid !== 1'b0 || msg_len !== 4'd8) begin fails++; $display("[TB] FAIL full_before_last: got valid=%b len=%0d expected valid=0 len=8", msg_valid, msg_len); end
    send(8'h49);
    checks++; if (msg_valid !== 1'b1) begin fails++; $display("[TB] FAIL full_valid: got %b expected 1", msg_valid); end
    checks++; if (msg_len !== 4'd9) begin fails++; $display("[TB] FAIL full_len: got %0d expected 9", msg_len); end
    checks++; if (bits_out !== exp_full) begin fails++; $display("[TB] FAIL full_bits: got %h expected %h", bits_out, exp_full); end
    send(8'h4A);
    checks++; if (overrun !== 1'b1) begin fails++; $display("[TB] FAIL full_overrun: got %b expected 1", overrun); end
    checks++; if (bits_out !== exp_full || msg_len !== 4'd9) begin fails++; $display("[TB] FAIL full_frozen: got len=%0d bits=%h expected len=9 bits=%h", msg_len, bits_out, exp_full); end
    cycle();
    checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL full_overrun_pulse: got %b expected 0", overrun); end
    send(8'h4B);
    send(8'h4C);
    checks++; if (overrun !== 1'b1) begin fails++; $display("[TB] FAIL full_overrun_second: got %b expected 1", overrun); end
    ack();
    checks++; if (msg_len !== 4'd0 || bits_out !== ALL_SP || overrun !== 1'b0) begin fails++; $display("[TB] FAIL full_ack_clear: got len=%0d bits=%h ovr=%b expected len=0 bits=%h ovr=0", msg_len, bits_out, overrun, ALL_SP); end
  endtask

  task automatic test_backspace();
    send(8'h41);
    send(8'h42);
    send(8'h08);
    checks++; if (msg_len !== 4'd1) begin fails++; $display("[TB] FAIL bs_len: got %0d expected 1", msg_len); end
    checks++; if (bits_out !== {{8{8'h20}}, 8'h41}) begin fails++; $display("[TB] FAIL bs_bits: got %h expected %h", bits_out, {{8{8'h20}}, 8'h41}); end
    send(8'h43);
    send(8'h0D);
    checks++; if (bits_out !== {{7{8'h20}}, 8'h43, 8'h41}) begin fails++; $display("[TB] FAIL bs_final_bits: got %h expected %h", bits_out, {{7{8'h20}}, 8'h43, 8'h41}); end
    checks++; if (msg_len !== 4'd2 || msg_valid !== 1'b1) begin fails++; $display("[TB] FAIL bs_final_len: got len=%0d valid=%b expected len=2 valid=1", msg_len, msg_valid); end
    ack();
  endtask

  task automatic test_empty_controls();
    send(8'h0D);
    checks++; if (msg_valid !== 1'b0 || msg_len !== 4'd0 || overrun !== 1'b0) begin fails++; $display("[TB] FAIL empty_cr: got valid=%b len=%0d ovr=%b expected 0 0 0", msg_valid, msg_len, overrun); end
    send(8'h0A);
    checks++; if (msg_valid !== 1'b0 || msg_len !== 4'd0) begin fails++; $display("[TB] FAIL empty_lf: got valid=%b len=%0d expected 0 0", msg_valid, msg_len); end
    send(8'h08);
    checks++; if (msg_len !== 4'd0 || bits_out !== ALL_SP || overrun !== 1'b0) begin fails++; $display("[TB] FAIL empty_bs: got len=%0d bits=%h ovr=%b expected len=0 bits=%h ovr=0", msg_len, bits_out, overrun, ALL_SP); end
    send(8'h4B);
    checks++; if (msg_len !== 4'd1 || bits_out[7:0] !== 8'h4B) begin fails++; $display("[TB] FAIL empty_then_char: got len=%0d slot0=%h expected len=1 slot0=4b", msg_len, bits_out[7:0]); end
    ack();
    checks++; if (msg_len !== 4'd1 || msg_valid !== 1'b0) begin fails++; $display("[TB] FAIL collect_ack_ignored: got len=%0d valid=%b expected len=1 valid=0", msg_len, msg_valid); end
    send(8'h08);
    checks++; if (msg_len !== 4'd0 || bits_out !== ALL_SP) begin fails++; $display("[TB] FAIL empty_restore: got len=%0d bits=%h expected len=0 bits=%h", msg_len, bits_out, ALL_SP); end
  endtask

  task automatic test_ack_collision();
    send(8'h41);
    send(8'h0D);
    checks++; if (msg_valid !== 1'b1) begin fails++; $display("[TB] FAIL coll_hold: got %b expected 1", msg_valid); end
    msg_ack     = 1'b1;
    new_rx_data = 1'b1;
    rx_data     = 8'h5A;
    cycle();
    msg_ack     = 1'b0;
    new_rx_data = 1'b0;
    rx_data     = 8'h00;
    checks++; if (overrun !== 1'b1) begin fails++; $display("[TB] FAIL coll_overrun: got %b expected 1", overrun); end
    checks++; if (msg_len !== 4'd0 || bits_out !== ALL_SP || msg_valid !== 1'b0) begin fails++; $display("[TB] FAIL coll_clear: got len=%0d bits=%h valid=%b expected len=0 bits=%h valid=0", msg_len, bits_out, msg_valid, ALL_SP); end
    cycle();
    checks++; if (overrun !== 1'b0 || msg_len !== 4'd0) begin fails++; $display("[TB] FAIL coll_after: got ovr=%b len=%0d expected ovr=0 len=0", overrun, msg_len); end
    send(8'h4E);
    checks++; if (msg_len !== 4'd1 || bits_out[7:0] !== 8'h4E) begin fails++; $display("[TB] FAIL coll_collect: got len=%0d slot0=%h expected len=1 slot0=4e", msg_len, bits_out[7:0]); end
    send(8'h08);
  endtask

  task automatic test_reset_mid();
    send(8'h58);
    send(8'h59);
    rst_n       = 1'b0;
    new_rx_data = 1'b1;
    rx_data     = 8'h52;
    cycle();
    rst_n       = 1'b1;
    new_rx_data = 1'b0;
    rx_data     = 8'h00;
    checks++; if (bits_out !== ALL_SP || msg_len !== 4'd0 || msg_valid !== 1'b0 || overrun !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset: got bits=%h len=%0d valid=%b ovr=%b expected bits=%h len=0 valid=0 ovr=0", bits_out, msg_len, msg_valid, overrun, ALL_SP); end
    send(8'h51);
    checks++; if (bits_out !== {{8{8'h20}}, 8'h51} || msg_len !== 4'd1) begin fails++; $display("[TB] FAIL mid_after: got bits=%h len=%0d expected bits=%h len=1", bits_out, msg_len, {{8{8'h20}}, 8'h51}); end
    send(8'h0D);
    rst_n       = 1'b0;
    new_rx_data = 1'b1;
    rx_data     = 8'h57;
    cycle();
    rst_n       = 1'b1;
    new_rx_data = 1'b0;
    rx_data     = 8'h00;
    checks++; if (overrun !== 1'b0 || msg_valid !== 1'b0 || msg_len !== 4'd0 || bits_out !== ALL_SP) begin fails++; $display("[TB] FAIL hold_reset: got ovr=%b valid=%b len=%0d bits=%h expected ovr=0 valid=0 len=0 bits=%h", overrun, msg_valid, msg_len, bits_out, ALL_SP); end
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_data     = 8'h00;
    new_rx_data = 1'b0;
    msg_ack     = 1'b0;
    test_reset();
    test_hi_cr();
    test_full();
    test_backspace();
    test_empty_controls();
    test_ack_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/message_capture.md
MESSAGE_CAPTURE -- requirements
Module: message_capture

Interface
REQ-001 Parameter MSG_LEN, default 9, number of character slots in the packed message (bytes).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 rx_data  input  8  received character from the UART receiver.
REQ-005 new_rx_data  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 msg_ack  input  1  printer side has consumed the held message.
REQ-007 bits_out  output  8*MSG_LEN  packed message; slot i occupies bits [8*i+7 : 8*i], slot 0 = first character typed.
REQ-008 msg_len  output  4  number of characters stored (0..MSG_LEN).
REQ-009 msg_valid  output  1  message complete and held stable.
REQ-010 overrun  output  1  one-cycle pulse when a received byte is dropped.

Function
REQ-011 Two states, COLLECT and HOLD; the state register and all outputs are registered (no combinational paths from input to output).
REQ-012 COLLECT, new_rx_data with rx_data = 0x0D or 0x0A and msg_len > 0: next cycle state = HOLD and msg_valid = 1; buffer unchanged.
REQ-013 COLLECT, CR/LF with msg_len = 0: ignored; no state change, no overrun.
REQ-014 COLLECT, rx_data = 0x08 (backspace): if msg_len > 0, slot msg_len-1 := 0x20 and msg_len decrements; if msg_len = 0, ignored.
REQ-015 COLLECT, any other byte: slot msg_len := rx_data and msg_len increments, visible the cycle after the strobe (latency 1).
REQ-016 Storing into slot MSG_LEN-1 moves the block to HOLD on the same edge (auto-terminate on full); msg_valid = 1 the next cycle.
REQ-017 HOLD: bits_out and msg_len frozen; every new_rx_data is dropped and overrun pulses high for exactly one cycle per dropped byte.
REQ-018 HOLD, msg_ack = 1: next cycle all slots = 0x20, msg_len = 0, msg_valid = 0, state = COLLECT.
REQ-019 HOLD, msg_ack and new_rx_data in the same cycle: ack wins, byte dropped, overrun pulses.
REQ-020 COLLECT, msg_ack = 1: ignored.
REQ-021 Unused slots always read 0x20 (space), so a downstream reader sees blanks beyond msg_len.
REQ-022 msg_len never exceeds MSG_LEN and never underflows below 0.

Reset
REQ-023 rst_n = 0 at a rising edge: state = COLLECT, all slots = 0x20, msg_len = 0, msg_valid = 0, overrun = 0.
REQ-024 Reset asserted mid-collection or in HOLD discards the partial or held message with no overrun pulse; reset has priority over all inputs.

Structure
REQ-025 Shared package holds the state enum (COLLECT, HOLD) and ASCII constants CR = 0x0D, LF = 0x0A, BS = 0x08, SPACE = 0x20.
REQ-026 Single module with no sub-modules; slot write/clear uses an indexed part-select on the packed register.

Verification
REQ-027 Reset, then type "HI" + 0x0D -> msg_valid = 1, msg_len = 2, bits_out[15:0] = 0x4948, all other slots = 0x20.
REQ-028 Type 9 bytes "ABCDEFGHI" with no CR -> HOLD after the 9th strobe, msg_len = 9; 10th byte "J" -> overrun pulse, buffer unchanged.
REQ-029 Type "AB", 0x08, "C", 0x0D -> slot0 = 0x41, slot1 = 0x43, msg_len = 2.
REQ-030 0x0D at msg_len = 0 and 0x08 at msg_len = 0 -> no state change, msg_valid = 0, overrun = 0.
REQ-031 In HOLD, drive msg_ack and new_rx_data ("Z") together -> overrun = 1 for one cycle, next cycle msg_len = 0, all slots = 0x20, COLLECT.
REQ-032 Store "XY", then rst_n = 0 for 1 cycle -> all outputs at reset values; next "Q" lands in slot 0.
